// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: state encoding and default widths
// shared by the RAM access sequencer files.
package mem_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam int ST_W       = 3;

  localparam logic [ST_W-1:0] IDLE    = 3'd0;
  localparam logic [ST_W-1:0] WAIT_WD = 3'd1;
  localparam logic [ST_W-1:0] SETUP   = 3'd2;
  localparam logic [ST_W-1:0] STROBE  = 3'd3;
  localparam logic [ST_W-1:0] HOLD    = 3'd4;
  localparam logic [ST_W-1:0] RELEASE = 3'd5;
  localparam logic [ST_W-1:0] RESP    = 3'd6;
  localparam logic [ST_W-1:0] NEXT    = 3'd7;

  // oe is high exactly while the FSM sits in STROBE or HOLD
  function automatic logic oe_state(input logic [ST_W-1:0] s);
    return (s == STROBE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/mem_seq_addr_gen.sv
// mem_seq_addr_gen: loadable wrapping address register
// plus beat down-counter with a last-beat flag.
module mem_seq_addr_gen
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W:0] CNT_ONE =
    {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  // Counter holds beats left including the current one;
  // a step on the last beat is refused so it never underflows.
  assign last_o = (cnt_q <= CNT_ONE);
  assign addr_o = addr_q;

  // Load on accept, advance (wrapping) between beats
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = {1'b0, len_i} + CNT_ONE;
    end else if (step_i && !last_o) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - CNT_ONE;
    end
  end

  // Address and beat count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: burst sequencer that drives glitch-free
// control sequences into a level-sensitive RAM.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              mem_r_w,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dato_w,
  input  logic [DATA_W-1:0] mem_dato
);

  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYC - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic [1:0]        hold_cnt_q, hold_cnt_d;
  logic              mem_oe_q;
  logic              mem_r_w_q;
  logic [DATA_W-1:0] mem_dato_w_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic accept;
  logic wd_take;
  logic hold_last;
  logic rd_capture;
  logic step;
  logic last_beat;

  assign req_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WAIT_WD);
  assign busy      = (state_q != IDLE);

  assign accept     = req_ready && req_valid;
  assign wd_take    = wr_ready && wr_valid;
  assign hold_last  = (hold_cnt_q == HOLD_LAST);
  assign rd_capture = (state_q == HOLD) && hold_last
                      && !mem_r_w_q;
  assign step       = (state_q == NEXT);

  mem_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .step_i (step),
    .addr_i (req_addr),
    .len_i  (req_len),
    .addr_o (mem_address),
    .last_o (last_beat)
  );

  // Next-state logic of the access sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid)
          state_d = req_write ? WAIT_WD : SETUP;
      end
      WAIT_WD: begin
        if (wr_valid) state_d = SETUP;
      end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD: begin
        if (hold_last) state_d = RELEASE;
      end
      RELEASE: state_d = mem_r_w_q ? NEXT : RESP;
      RESP: begin
        if (rd_ready) state_d = NEXT;
      end
      NEXT: begin
        if (last_beat)      state_d = IDLE;
        else if (mem_r_w_q) state_d = WAIT_WD;
        else                state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counts cycles spent in HOLD
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == HOLD) hold_cnt_d = hold_cnt_q + 2'd1;
  end

  // State and registered outputs; oe and rd_valid are
  // computed from the next state so they are plain flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      mem_oe_q     <= 1'b0;
      mem_r_w_q    <= 1'b0;
      mem_dato_w_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mem_oe_q   <= oe_state(state_d);
      rd_valid_q <= (state_d == RESP);
      if (accept)     mem_r_w_q    <= req_write;
      if (wd_take)    mem_dato_w_q <= wr_data;
      if (rd_capture) rd_data_q    <= mem_dato;
    end
  end

  assign mem_oe     = mem_oe_q;
  assign mem_r_w    = mem_r_w_q;
  assign mem_dato_w = mem_dato_w_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

endmodule
